seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 182 ++++++++++++++++++
 tb/tb_seq_alu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU. Operands and opcode are captured on start in IDLE.
// ADD/SUB/AND/OR/XOR/SHL1 take one EXEC cycle. MUL (shift-add) and DIV
// (restoring) take DATA_WIDTH ITER cycles. Every operation ends in one WB cycle
// that pulses we/done.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin an operation (sampled only in IDLE)
//   op                opcode: 000 ADD, 001 SUB, 010 AND, 011 OR,
//                     100 XOR, 101 SHL1, 110 MUL, 111 DIV
//   acc_in, operand   left / right operands
//   busy              high in every state except IDLE
//   we, done          accumulator load strobe / completion pulse (WB cycle)
//   data_alu          result register
//   zero, carry       result flags, registered on entry to WB
module seq_alu #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] acc_in,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic                  busy,
  output logic                  we,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_alu,
  output logic                  zero,
  output logic                  carry
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, EXEC, ITER, WB} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_MUL = 3'b110, OP_DIV = 3'b111
  } op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [2*W-1:0]  work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    res_q, res_d;
  logic            zero_q, zero_d, carry_q, carry_d;

  op_e             op_in;
  logic [W:0]      simple_res;
  logic [W:0]      mul_upper;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_rem, div_diff;
  logic            div_ge;
  logic [W-1:0]    div_rem_new;
  logic [2*W-1:0]  div_next;

  assign op_in = op_e'(op);

  // Single-cycle ops; bit W carries the carry/borrow/shifted-out flag.
  always_comb begin
    simple_res = '0;
    case (op_q)
      OP_ADD:  simple_res = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  simple_res = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  simple_res = {1'b0, a_q & b_q};
      OP_OR:   simple_res = {1'b0, a_q | b_q};
      OP_XOR:  simple_res = {1'b0, a_q ^ b_q};
      OP_SHL:  simple_res = {a_q, 1'b0};
      default: simple_res = '0;
    endcase
  end

  // MUL step: work = {high, multiplier/low}. Add multiplicand into the high
  // half when the current multiplier bit is set, then shift right by one.
  always_comb begin
    mul_upper = {1'b0, work_q[2*W-1:W]} + {1'b0, (work_q[0] ? a_q : {W{1'b0}})};
    mul_next  = {mul_upper, work_q[W-1:1]};
  end

  // DIV step: work = {remainder, dividend/quotient}. Shift one dividend bit
  // into the remainder and subtract the divisor if it fits. A zero divisor
  // always fits, so the quotient naturally comes out all ones.
  always_comb begin
    div_rem     = {work_q[2*W-1:W], work_q[W-1]};
    div_diff    = div_rem - {1'b0, b_q};
    div_ge      = ~div_diff[W];
    div_rem_new = div_ge ? div_diff[W-1:0] : div_rem[W-1:0];
    div_next    = {div_rem_new, work_q[W-2:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op_in;
          a_d   = acc_in;
          b_d   = operand;
          cnt_d = '0;
          if (op_in == OP_MUL) begin
            state_d = ITER;
            work_d  = {{W{1'b0}}, operand};
          end else if (op_in == OP_DIV) begin
            state_d = ITER;
            work_d  = {{W{1'b0}}, acc_in};
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d = WB;
        res_d   = simple_res[W-1:0];
        carry_d = simple_res[W];
        zero_d  = (simple_res[W-1:0] == '0);
      end
      ITER: begin
        work_d = (op_q == OP_MUL) ? mul_next : div_next;
        cnt_d  = cnt_q + CW'(1);
        // The last step's result goes straight into the output registers.
        if (cnt_q == CW'(W-1)) begin
          state_d = WB;
          if (op_q == OP_MUL) begin
            res_d   = mul_next[W-1:0];
            carry_d = (mul_next[2*W-1:W] != '0);
            zero_d  = (mul_next[W-1:0] == '0);
          end else begin
            res_d   = div_next[W-1:0];
            carry_d = (b_q == '0);
            zero_d  = (div_next[W-1:0] == '0);
          end
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign we       = (state_q == WB);
  assign done     = (state_q == WB);
  assign data_alu = res_q;
  assign zero     = zero_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu (DATA_WIDTH=8). The driver
// pushes expected results into a queue; a negedge monitor pops and checks on
// every we pulse, including the edge number at which the pulse appears.
module tb_seq_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [2:0]   op;
  logic [W-1:0] acc_in, operand;
  logic         busy, we, done, zero, carry;
  logic [W-1:0] data_alu;

  seq_alu #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .acc_in(acc_in),
    .operand(operand), .busy(busy), .we(we), .done(done),
    .data_alu(data_alu), .zero(zero), .carry(carry)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         z;
    logic         c;
    int unsigned  edge_no;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every we pulse must match the oldest expectation.
  exp_t e_mon;
  always @(negedge clk) begin
    if (we) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: got we=1 at edge %0d, expected no pulse", edge_cnt);
      end else begin
        e_mon = sb.pop_front();
        check({e_mon.name, "_res"},   32'(data_alu), 32'(e_mon.res));
        check({e_mon.name, "_zero"},  32'(zero),     32'(e_mon.z));
        check({e_mon.name, "_carry"}, 32'(carry),    32'(e_mon.c));
        check({e_mon.name, "_edge"},  edge_cnt,      e_mon.edge_no);
        check({e_mon.name, "_done"},  32'(done),     32'd1);
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles, expected idle", name, n);
    end
  endtask

  // Called at a negedge; start is seen at the next posedge (edge 0).
  task automatic do_op(input string name, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] r, input logic z,
                       input logic c, input int unsigned lat);
    exp_t e;
    start = 1'b1; op = o; acc_in = a; operand = b;
    e.name = name; e.res = r; e.z = z; e.c = c; e.edge_no = edge_cnt + 1 + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; op = ~o; acc_in = W'($urandom); operand = W'($urandom);
    wait_idle(name);
    check({name, "_hold"}, 32'(data_alu), 32'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected end of run");
    $fatal(1);
  end

  initial begin
    bit seen_we, any_busy, dropped;
    int n;
    // Reset with start asserted: reset must win.
    rst = 1'b1; start = 1'b1; op = 3'b000; acc_in = 8'h11; operand = 8'h22;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_we",   32'(we),   0);
    check("rst_done", 32'(done), 0);
    check("rst_data", 32'(data_alu), 0);
    check("rst_zero", 32'(zero),  0);
    check("rst_carry", 32'(carry), 0);
    start = 1'b0; rst = 1'b0;

    //     name      op     a      b      res    z     c     lat
    do_op("add_ff",  3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1);
    do_op("sub_bor", 3'd1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1);
    do_op("and",     3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1);
    do_op("or",      3'd3, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1);
    do_op("xor",     3'd4, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1);
    do_op("shl",     3'd5, 8'h81, 8'h3C, 8'h02, 1'b0, 1'b1, 1);
    do_op("add",     3'd0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1);
    do_op("sub",     3'd1, 8'h07, 8'h05, 8'h02, 1'b0, 1'b0, 1);
    do_op("mul_ovf", 3'd6, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 8);
    do_op("mul",     3'd6, 8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0, 8);
    do_op("mul_ff",  3'd6, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 8);
    do_op("div",     3'd7, 8'h64, 8'h07, 8'h0E, 1'b0, 1'b0, 8);
    do_op("div_z",   3'd7, 8'h55, 8'h00, 8'hFF, 1'b0, 1'b1, 8);
    do_op("div_0q",  3'd7, 8'h03, 8'h09, 8'h00, 1'b1, 1'b0, 8);

    // Start pulsed during MUL ITER must be ignored.
    begin
      exp_t e;
      start = 1'b1; op = 3'd6; acc_in = 8'h0C; operand = 8'h0B;
      e.name = "mul_ign"; e.res = 8'h84; e.z = 1'b0; e.c = 1'b0; e.edge_no = edge_cnt + 9;
      sb.push_back(e);
      @(negedge clk); start = 1'b0; op = 3'd0; acc_in = 8'h55; operand = 8'hAA;
      repeat (2) @(negedge clk);
      start = 1'b1; op = 3'd0; acc_in = 8'h01; operand = 8'h01;
      @(negedge clk); start = 1'b0;
      seen_we = 1'b0; dropped = 1'b0; n = 0;
      while (n < 40) begin
        if (we) seen_we = 1'b1;
        if (!busy) begin
          if (!seen_we) dropped = 1'b1;
          break;
        end
        @(negedge clk);
        n++;
      end
      check("mul_ign_busy_cont", 32'(dropped), 0);
      check("mul_ign_we_seen", 32'(seen_we), 1);
      any_busy = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (busy) any_busy = 1'b1;
      end
      check("mul_ign_no_queue", 32'(any_busy), 0);
    end

    // Start during WB must be ignored.
    begin
      exp_t e;
      start = 1'b1; op = 3'd0; acc_in = 8'h12; operand = 8'h01;
      e.name = "wb_add"; e.res = 8'h13; e.z = 1'b0; e.c = 1'b0; e.edge_no = edge_cnt + 2;
      sb.push_back(e);
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!we && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("wb_reached", 32'(we), 1);
      start = 1'b1; op = 3'd0; acc_in = 8'h03; operand = 8'h04;
      @(negedge clk); start = 1'b0;
      check("wb_start_ign", 32'(busy), 0);
      @(negedge clk);
      check("wb_start_ign2", 32'(busy), 0);
    end

    // Reset in ITER cycle 4 of a DIV aborts with no we pulse.
    start = 1'b1; op = 3'd7; acc_in = 8'h64; operand = 8'h07;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_iter", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",  32'(busy), 0);
    check("abort_we",    32'(we), 0);
    check("abort_data",  32'(data_alu), 0);
    check("abort_zero",  32'(zero), 0);
    check("abort_carry", 32'(carry), 0);
    do_op("post_rst_add", 3'd0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1);
    repeat (12) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
